// File: rtl/fakeram_1rw1r_param_sram.sv
// Behavioural 1RW+1R SRAM: zero-init sweep after reset, 1/2-cycle read latency with valid strobes,
// optional r0 write-bypass on same-address collision, out-of-range flagging. No backpressure.
module fakeram_1rw1r_param_sram #(
   parameter int BITS               = 32,
   parameter int WORD_DEPTH         = 384,
   parameter int ADDR_WIDTH         = $clog2(WORD_DEPTH),
   parameter int MASK_BITS          = 8,
   parameter int READ_LATENCY       = 1,
   parameter bit BYPASS_MODE        = 1'b0,
   parameter bit INIT_ON_RESET      = 1'b1,
   parameter bit corrupt_mem_on_X_p = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      init_busy_out,
   input  logic                      r0_ce_in,
   input  logic [ADDR_WIDTH-1:0]     r0_addr_in,
   output logic [BITS-1:0]           r0_rd_out,
   output logic                      r0_valid_out,
   input  logic                      rw0_ce_in,
   input  logic                      rw0_we_in,
   input  logic [ADDR_WIDTH-1:0]     rw0_addr_in,
   input  logic [BITS-1:0]           rw0_wd_in,
   input  logic [BITS/MASK_BITS-1:0] rw0_wmask_in,
   output logic [BITS-1:0]           rw0_rd_out,
   output logic                      rw0_valid_out,
   output logic                      oob_err_out
);
   localparam int LANES = BITS / MASK_BITS;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(WORD_DEPTH);

   if (BITS % MASK_BITS != 0) begin : g_bad_mask
      $fatal(1, "BITS (%0d) must be a multiple of MASK_BITS (%0d)", BITS, MASK_BITS);
   end
   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
      $fatal(1, "READ_LATENCY must be 1 or 2, got %0d", READ_LATENCY);
   end

   typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_READY} state_t;

   state_t                          state_q, state_d;
   logic [ADDR_WIDTH-1:0]           init_cnt_q, init_cnt_d;
   logic [WORD_DEPTH-1:0][BITS-1:0] mem_q;

   logic                  ready, r0_in_rng, rw0_in_rng, wr_en, mem_corrupt;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [LANES-1:0]      wr_mask;
   logic [BITS-1:0]       wr_src, wr_word, r0_old;
   logic                  p_r0_vld_d, p_rw0_vld_d, p_oob_d;
   logic [BITS-1:0]       p_r0_dat_d, p_rw0_dat_d;
   logic                  s_r0_vld, s_rw0_vld, s_oob;
   logic [BITS-1:0]       s_r0_dat, s_rw0_dat;
   logic                  r0_vld_q, r0_vld_d, rw0_vld_q, rw0_vld_d, oob_q, oob_d;
   logic [BITS-1:0]       r0_rd_q, r0_rd_d, rw0_rd_q, rw0_rd_d;

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      case (state_q)
         ST_RESET: begin
            init_cnt_d = '0;
            state_d    = INIT_ON_RESET ? ST_INIT : ST_READY;
         end
         ST_INIT: begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == LAST_ADDR) state_d = ST_READY;
         end
         default: state_d = ST_READY;
      endcase
   end

   always_comb begin
      ready       = (state_q == ST_READY) && !rst;
      r0_in_rng   = {1'b0, r0_addr_in} < DEPTH_EXT;
      rw0_in_rng  = {1'b0, rw0_addr_in} < DEPTH_EXT;
      p_r0_vld_d  = ready & r0_ce_in;
      p_rw0_vld_d = ready & rw0_ce_in;
      p_oob_d     = (p_r0_vld_d & ~r0_in_rng) | (p_rw0_vld_d & ~rw0_in_rng);
      r0_old      = r0_in_rng ? mem_q[r0_addr_in] : '0;
      p_rw0_dat_d = rw0_in_rng ? mem_q[rw0_addr_in] : '0;
      mem_corrupt = corrupt_mem_on_X_p && ready && rw0_ce_in && $isunknown({rw0_we_in, rw0_addr_in});
      // The init sweep borrows the write path; functional ports are locked out meanwhile.
      if (state_q == ST_INIT && !rst) begin
         wr_en   = 1'b1;
         wr_addr = init_cnt_q;
         wr_src  = '0;
         wr_mask = '1;
      end else begin
         wr_en   = p_rw0_vld_d & rw0_we_in & rw0_in_rng;
         wr_addr = rw0_addr_in;
         wr_src  = rw0_wd_in;
         wr_mask = rw0_wmask_in;
      end
      wr_word = mem_q[wr_addr];
      for (int i = 0; i < LANES; i++) begin
         if (wr_mask[i]) wr_word[i*MASK_BITS +: MASK_BITS] = wr_src[i*MASK_BITS +: MASK_BITS];
      end
      p_r0_dat_d = r0_old;
      if (BYPASS_MODE && p_r0_vld_d && wr_en && (r0_addr_in == rw0_addr_in)) p_r0_dat_d = wr_word;
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic           p_r0_vld_q, p_rw0_vld_q, p_oob_q;
      logic [BITS-1:0] p_r0_dat_q, p_rw0_dat_q;
      always_ff @(posedge clk) begin
         if (rst) begin
            p_r0_vld_q  <= 1'b0;
            p_rw0_vld_q <= 1'b0;
            p_oob_q     <= 1'b0;
            p_r0_dat_q  <= '0;
            p_rw0_dat_q <= '0;
         end else begin
            p_r0_vld_q  <= p_r0_vld_d;
            p_rw0_vld_q <= p_rw0_vld_d;
            p_oob_q     <= p_oob_d;
            p_r0_dat_q  <= p_r0_dat_d;
            p_rw0_dat_q <= p_rw0_dat_d;
         end
      end
      assign s_r0_vld  = p_r0_vld_q;
      assign s_rw0_vld = p_rw0_vld_q;
      assign s_oob     = p_oob_q;
      assign s_r0_dat  = p_r0_dat_q;
      assign s_rw0_dat = p_rw0_dat_q;
   end else begin : g_lat1
      assign s_r0_vld  = p_r0_vld_d;
      assign s_rw0_vld = p_rw0_vld_d;
      assign s_oob     = p_oob_d;
      assign s_r0_dat  = p_r0_dat_d;
      assign s_rw0_dat = p_rw0_dat_d;
   end

   always_comb begin
      r0_vld_d  = s_r0_vld;
      rw0_vld_d = s_rw0_vld;
      oob_d     = s_oob;
      r0_rd_d   = s_r0_vld ? s_r0_dat : r0_rd_q;
      rw0_rd_d  = s_rw0_vld ? s_rw0_dat : rw0_rd_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RESET;
         init_cnt_q <= '0;
         r0_vld_q   <= 1'b0;
         rw0_vld_q  <= 1'b0;
         oob_q      <= 1'b0;
         r0_rd_q    <= '0;
         rw0_rd_q   <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         r0_vld_q   <= r0_vld_d;
         rw0_vld_q  <= rw0_vld_d;
         oob_q      <= oob_d;
         r0_rd_q    <= r0_rd_d;
         rw0_rd_q   <= rw0_rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_corrupt) mem_q <= 'x;
      else if (wr_en)  mem_q[wr_addr] <= wr_word;
   end

   assign init_busy_out = (state_q != ST_READY);
   assign r0_rd_out     = r0_rd_q;
   assign r0_valid_out  = r0_vld_q;
   assign rw0_rd_out    = rw0_rd_q;
   assign rw0_valid_out = rw0_vld_q;
   assign oob_err_out   = oob_q;
endmodule

// File: tb/tb_fakeram_1rw1r_param_sram.sv
// Two instances (latency 1 / no bypass, latency 2 / bypass) share stimulus; a word-array
// reference model feeds per-instance expectation queues drained by a negedge monitor.
`timescale 1ns/1ps
module tb_fakeram_1rw1r_param_sram;
   localparam int DEPTH = 384;
   localparam int AW    = 9;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, r0_ce, rw0_ce, rw0_we;
   logic [AW-1:0]    r0_addr, rw0_addr;
   logic [31:0]      rw0_wd;
   logic [3:0]       rw0_wmask;
   logic [1:0]       busy, r0_vld, rw_vld, oob;
   logic [1:0][31:0] r0_rd, rw_rd;

   fakeram_1rw1r_param_sram #(.READ_LATENCY(1), .BYPASS_MODE(1'b0)) dut0 (
      .clk(clk), .rst(rst), .init_busy_out(busy[0]),
      .r0_ce_in(r0_ce), .r0_addr_in(r0_addr), .r0_rd_out(r0_rd[0]), .r0_valid_out(r0_vld[0]),
      .rw0_ce_in(rw0_ce), .rw0_we_in(rw0_we), .rw0_addr_in(rw0_addr), .rw0_wd_in(rw0_wd),
      .rw0_wmask_in(rw0_wmask), .rw0_rd_out(rw_rd[0]), .rw0_valid_out(rw_vld[0]), .oob_err_out(oob[0]));

   fakeram_1rw1r_param_sram #(.READ_LATENCY(2), .BYPASS_MODE(1'b1)) dut1 (
      .clk(clk), .rst(rst), .init_busy_out(busy[1]),
      .r0_ce_in(r0_ce), .r0_addr_in(r0_addr), .r0_rd_out(r0_rd[1]), .r0_valid_out(r0_vld[1]),
      .rw0_ce_in(rw0_ce), .rw0_we_in(rw0_we), .rw0_addr_in(rw0_addr), .rw0_wd_in(rw0_wd),
      .rw0_wmask_in(rw0_wmask), .rw0_rd_out(rw_rd[1]), .rw0_valid_out(rw_vld[1]), .oob_err_out(oob[1]));

   typedef struct {
      int          issue;
      logic        r0v;
      logic [31:0] r0d;
      logic        rwv;
      logic [31:0] rwd;
      logic        oob;
   } exp_t;

   exp_t        sbq[2][$];
   logic [31:0] last_r0[2];
   logic [31:0] last_rw[2];
   logic [31:0] ref_mem[DEPTH];
   bit          mon_on = 1'b0;
   int          e = 0;
   int          total = 0;
   int          bad = 0;

   always @(posedge clk) e <= e + 1;

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d got=%h want=%h t=%0t", nm, k, act, exp, $time);
      end
   endtask

   task automatic mon(input int k);
      exp_t x;
      int   lat;
      lat = k + 1;
      if (r0_vld[k] || rw_vld[k]) begin
         if (sbq[k].size() == 0) begin
            chk("unexpected_valid", k, {r0_vld[k], rw_vld[k]}, 0);
         end else begin
            x = sbq[k].pop_front();
            chk("latency", k, e, x.issue + lat - 1);
            chk("r0_valid", k, r0_vld[k], x.r0v);
            chk("rw0_valid", k, rw_vld[k], x.rwv);
            chk("oob_err", k, oob[k], x.oob);
            if (x.r0v) last_r0[k] = x.r0d;
            if (x.rwv) last_rw[k] = x.rwd;
         end
      end else begin
         chk("oob_idle", k, oob[k], 0);
         if (sbq[k].size() != 0 && e > sbq[k][0].issue + lat - 1) begin
            chk("missing_valid", k, e, sbq[k][0].issue + lat - 1);
            void'(sbq[k].pop_front());
         end
      end
      chk("r0_rd", k, r0_rd[k], last_r0[k]);
      chk("rw0_rd", k, rw_rd[k], last_rw[k]);
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         for (int k = 0; k < 2; k++) mon(k);
      end
   end

   task automatic issue(input bit rc, input int ra, input bit wc, input bit we, input int wa,
                        input logic [31:0] wd, input logic [3:0] m);
      logic [31:0] old_r, old_w, new_w;
      bit          r_in, w_in, wr;
      exp_t        x;
      @(negedge clk); #1;
      r0_ce = rc; r0_addr = AW'(ra);
      rw0_ce = wc; rw0_we = we; rw0_addr = AW'(wa); rw0_wd = wd; rw0_wmask = m;
      r_in = (ra < DEPTH);
      w_in = (wa < DEPTH);
      old_r = 32'h0;
      old_w = 32'h0;
      if (r_in) old_r = ref_mem[ra];
      if (w_in) old_w = ref_mem[wa];
      new_w = old_w;
      for (int i = 0; i < 4; i++) if (m[i]) new_w[8*i +: 8] = wd[8*i +: 8];
      wr = wc && we && w_in;
      if (rc || wc) begin
         for (int k = 0; k < 2; k++) begin
            x.issue = e + 1;
            x.r0v   = rc;
            x.r0d   = (k == 1 && wr && ra == wa) ? new_w : old_r;
            x.rwv   = wc;
            x.rwd   = old_w;
            x.oob   = (rc && !r_in) || (wc && !w_in);
            sbq[k].push_back(x);
         end
      end
      if (wr) ref_mem[wa] = new_w;
   endtask

   task automatic idle();
      @(negedge clk); #1;
      r0_ce = 1'b0; rw0_ce = 1'b0;
   endtask

   // mid_init pulses reset a second time about 100 words into the sweep.
   task automatic do_reset(input bit mid_init, input bit drain);
      int cnt[2];
      bit any_v[2];
      idle();
      repeat (3) @(negedge clk);
      if (drain) for (int k = 0; k < 2; k++) chk("drain", k, sbq[k].size(), 0);
      mon_on = 1'b0;
      #1 rst = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("rst_busy", k, busy[k], 1);
         chk("rst_r0_rd", k, r0_rd[k], 0);
         chk("rst_rw0_rd", k, rw_rd[k], 0);
         chk("rst_valids", k, {r0_vld[k], rw_vld[k], oob[k]}, 0);
      end
      #1 rst = 1'b0;
      if (mid_init) begin
         repeat (101) @(negedge clk);
         for (int k = 0; k < 2; k++) chk("busy_mid_init", k, busy[k], 1);
         #1 rst = 1'b1;
         @(negedge clk);
         #1 rst = 1'b0;
      end
      // Accesses offered during the sweep must be ignored.
      r0_ce = 1'b1; r0_addr = 9'd5;
      rw0_ce = 1'b1; rw0_we = 1'b1; rw0_addr = 9'd5; rw0_wd = 32'hFFFF_FFFF; rw0_wmask = 4'hF;
      cnt = '{1, 1};
      any_v = '{1'b0, 1'b0};
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (busy[k]) cnt[k]++;
            if (r0_vld[k] || rw_vld[k] || oob[k]) any_v[k] = 1'b1;
         end
         if (busy == 2'b00) break;
      end
      r0_ce = 1'b0; rw0_ce = 1'b0;
      for (int k = 0; k < 2; k++) begin
         chk("busy_cycles", k, cnt[k], DEPTH + 1);
         chk("init_no_valid", k, any_v[k], 0);
         sbq[k].delete();
         last_r0[k] = 32'h0;
         last_rw[k] = 32'h0;
      end
      for (int a = 0; a < DEPTH; a++) ref_mem[a] = 32'h0;
      mon_on = 1'b1;
   endtask

   function automatic int pick();
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) return $urandom_range(0, 15);
      if (r < 9) return $urandom_range(0, DEPTH - 1);
      return $urandom_range(DEPTH, 511);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0; r0_ce = 1'b0; rw0_ce = 1'b0; rw0_we = 1'b0;
      r0_addr = '0; rw0_addr = '0; rw0_wd = '0; rw0_wmask = '0;
      do_reset(1'b0, 1'b1);

      // Whole array reads zero after init, both ports streaming back-to-back.
      for (int a = 0; a < DEPTH; a += 2) issue(1'b1, a, 1'b1, 1'b0, a + 1, 32'h0, 4'h0);

      issue(1'b0, 0, 1'b1, 1'b1, 5, 32'hDEADBEEF, 4'b1111);
      issue(1'b1, 5, 1'b0, 1'b0, 0, 32'h0, 4'h0);
      issue(1'b0, 0, 1'b1, 1'b1, 5, 32'h11223344, 4'b0101);
      issue(1'b1, 5, 1'b0, 1'b0, 0, 32'h0, 4'h0);
      idle();
      issue(1'b1, 7, 1'b1, 1'b1, 7, 32'hAABBCCDD, 4'b0011);
      issue(1'b1, 7, 1'b0, 1'b0, 0, 32'h0, 4'h0);
      issue(1'b1, 400, 1'b0, 1'b0, 0, 32'h0, 4'h0);
      issue(1'b0, 0, 1'b1, 1'b1, 400, 32'hCAFEF00D, 4'hF);
      issue(1'b1, 400, 1'b1, 1'b0, 400, 32'h0, 4'h0);
      issue(1'b0, 0, 1'b1, 1'b1, 5, 32'h0, 4'h0);
      issue(1'b1, 5, 1'b0, 1'b0, 0, 32'h0, 4'h0);
      idle();
      idle();

      for (int i = 0; i < 1500; i++) begin
         bit rc, wc, we;
         int ra, wa;
         rc = ($urandom_range(0, 3) != 0);
         wc = ($urandom_range(0, 3) != 0);
         we = $urandom_range(0, 1) == 1;
         ra = pick();
         wa = pick();
         if ($urandom_range(0, 7) == 0) idle();
         else issue(rc, ra, wc, we, wa, $urandom, 4'($urandom));
      end
      idle();
      repeat (4) @(negedge clk);

      // Reset while a latency-2 read is in flight drops its valid.
      issue(1'b1, 9, 1'b0, 1'b0, 0, 32'h0, 4'h0);
      @(negedge clk); #1;
      rst = 1'b1; r0_ce = 1'b0; mon_on = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) chk("midread_valid", k, {r0_vld[k], rw_vld[k], oob[k]}, 0);
      for (int k = 0; k < 2; k++) sbq[k].delete();
      do_reset(1'b0, 1'b0);

      issue(1'b0, 0, 1'b1, 1'b1, 50, 32'h12345678, 4'hF);
      issue(1'b0, 0, 1'b1, 1'b1, 300, 32'h9ABCDEF0, 4'hF);
      do_reset(1'b1, 1'b1);
      issue(1'b1, 50, 1'b1, 1'b0, 300, 32'h0, 4'h0);
      issue(1'b1, 5, 1'b0, 1'b0, 0, 32'h0, 4'h0);
      idle();
      repeat (4) @(negedge clk);
      for (int k = 0; k < 2; k++) chk("final_drain", k, sbq[k].size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
